// File: rtl/status_reg_6502_if.sv
// Bus between the instruction sequencer and the 6502 processor status register.
// The sequencer side (master) drives flag sources; the register side (slave) returns flags.
interface status_reg_6502_if;
    logic       alu_c;
    logic       alu_z;
    logic       alu_n;
    logic       alu_v;
    logic       upd_valid;
    logic [3:0] upd_mask;
    logic [2:0] flag_op;
    logic       bit_load;
    logic       pl_load;
    logic [7:0] din;
    logic       brk_push;
    logic       insn_end;
    logic [7:0] p_out;
    logic       flag_n;
    logic       flag_v;
    logic       flag_d;
    logic       flag_i;
    logic       flag_z;
    logic       flag_c;
    logic       irq_mask;

    modport master (
        output alu_c, alu_z, alu_n, alu_v, upd_valid, upd_mask, flag_op,
               bit_load, pl_load, din, brk_push, insn_end,
        input  p_out, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c, irq_mask
    );

    modport slave (
        input  alu_c, alu_z, alu_n, alu_v, upd_valid, upd_mask, flag_op,
               bit_load, pl_load, din, brk_push, insn_end,
        output p_out, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c, irq_mask
    );
endinterface

// File: rtl/status_reg_6502.sv
// 6502 processor status register: six stored flags with prioritised update sources
// and an interrupt mask that follows I only at instruction boundaries.
module status_reg_6502 (
    input  logic                    clk,
    input  logic                    rst,
    status_reg_6502_if.slave        bus
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_CLC  = 3'd1;
    localparam logic [2:0] OP_SEC  = 3'd2;
    localparam logic [2:0] OP_CLI  = 3'd3;
    localparam logic [2:0] OP_SEI  = 3'd4;
    localparam logic [2:0] OP_CLD  = 3'd5;
    localparam logic [2:0] OP_SED  = 3'd6;
    localparam logic [2:0] OP_CLV  = 3'd7;

    logic n_r, v_r, d_r, i_r, z_r, c_r, irq_mask_r;
    logic n_s, v_s, d_s, i_s, z_s, c_s;
    logic unused_din_s;

    // B and bit 5 are not stored, so the pulled byte's [5:4] are dropped
    assign unused_din_s = ^bus.din[5:4];

    // Next-state: apply sources lowest priority first so higher ones overwrite per flag
    always_comb begin
        n_s = (bus.upd_valid && bus.upd_mask[3]) ? bus.alu_n : n_r;
        v_s = (bus.upd_valid && bus.upd_mask[2]) ? bus.alu_v : v_r;
        z_s = (bus.upd_valid && bus.upd_mask[1]) ? bus.alu_z : z_r;
        c_s = (bus.upd_valid && bus.upd_mask[0]) ? bus.alu_c : c_r;
        d_s = d_r;
        i_s = i_r;

        case (bus.flag_op)
            OP_NONE: ;
            OP_CLC:  c_s = 1'b0;
            OP_SEC:  c_s = 1'b1;
            OP_CLI:  i_s = 1'b0;
            OP_SEI:  i_s = 1'b1;
            OP_CLD:  d_s = 1'b0;
            OP_SED:  d_s = 1'b1;
            OP_CLV:  v_s = 1'b0;
            default: ;
        endcase

        if (bus.bit_load) begin
            n_s = bus.din[7];
            v_s = bus.din[6];
        end else begin
            n_s = n_s;
            v_s = v_s;
        end

        if (bus.pl_load) begin
            n_s = bus.din[7];
            v_s = bus.din[6];
            d_s = bus.din[3];
            i_s = bus.din[2];
            z_s = bus.din[1];
            c_s = bus.din[0];
        end else begin
            d_s = d_s;
            i_s = i_s;
        end
    end

    // Flag registers; reset overrides every source that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r <= 1'b0;
            v_r <= 1'b0;
            d_r <= 1'b0;
            i_r <= 1'b1;
            z_r <= 1'b0;
            c_r <= 1'b0;
        end else begin
            n_r <= n_s;
            v_r <= v_s;
            d_r <= d_s;
            i_r <= i_s;
            z_r <= z_s;
            c_r <= c_s;
        end
    end

    // Interrupt mask samples the post-priority I only on an instruction boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask_r <= 1'b1;
        end else if (bus.insn_end) begin
            irq_mask_r <= i_s;
        end else begin
            irq_mask_r <= irq_mask_r;
        end
    end

    assign bus.flag_n   = n_r;
    assign bus.flag_v   = v_r;
    assign bus.flag_d   = d_r;
    assign bus.flag_i   = i_r;
    assign bus.flag_z   = z_r;
    assign bus.flag_c   = c_r;
    assign bus.irq_mask = irq_mask_r;
    assign bus.p_out    = {n_r, v_r, 1'b1, bus.brk_push, d_r, i_r, z_r, c_r};

endmodule

// File: tb/tb_status_reg_6502.sv
// Scoreboard bench for status_reg_6502: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them against the DUT.
module tb_status_reg_6502;

    typedef struct {
        int         id;
        logic [5:0] flags;   // {N,V,D,I,Z,C}
        logic       irq;
        logic [7:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    exp_t exp_q[$];

    status_reg_6502_if bus();

    status_reg_6502 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: each edge's result is judged on the following falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] got_f;
            e = exp_q.pop_front();
            got_f = {bus.flag_n, bus.flag_v, bus.flag_d, bus.flag_i, bus.flag_z, bus.flag_c};
            checks++;
            if (got_f !== e.flags) begin
                errors++;
                $display("FAIL step%0d flags NVDIZC got %b want %b", e.id, got_f, e.flags);
            end
            checks++;
            if (bus.irq_mask !== e.irq) begin
                errors++;
                $display("FAIL step%0d irq_mask got %b want %b", e.id, bus.irq_mask, e.irq);
            end
            checks++;
            if (bus.p_out !== e.p) begin
                errors++;
                $display("FAIL step%0d p_out got %h want %h", e.id, bus.p_out, e.p);
            end
        end
    end

    task automatic step(
        input logic       r,
        input logic [3:0] alu_nvzc,
        input logic       uv,
        input logic [3:0] mask,
        input logic [2:0] op,
        input logic       bl,
        input logic       pl,
        input logic [7:0] d,
        input logic       brk,
        input logic       ie,
        input logic [5:0] ef,
        input logic       eirq,
        input logic [7:0] ep
    );
        exp_t e;
        @(negedge clk);
        #1;
        rst           = r;
        bus.alu_n     = alu_nvzc[3];
        bus.alu_v     = alu_nvzc[2];
        bus.alu_z     = alu_nvzc[1];
        bus.alu_c     = alu_nvzc[0];
        bus.upd_valid = uv;
        bus.upd_mask  = mask;
        bus.flag_op   = op;
        bus.bit_load  = bl;
        bus.pl_load   = pl;
        bus.din       = d;
        bus.brk_push  = brk;
        bus.insn_end  = ie;
        @(posedge clk);
        step_id++;
        e.id    = step_id;
        e.flags = ef;
        e.irq   = eirq;
        e.p     = ep;
        exp_q.push_back(e);
    endtask

    initial begin
        bus.alu_n = 1'b0; bus.alu_v = 1'b0; bus.alu_z = 1'b0; bus.alu_c = 1'b0;
        bus.upd_valid = 1'b0; bus.upd_mask = 4'h0; bus.flag_op = 3'd0;
        bus.bit_load = 1'b0; bus.pl_load = 1'b0; bus.din = 8'h00;
        bus.brk_push = 1'b0; bus.insn_end = 1'b0;

        //     rst   nvzc     uv    mask     op    bl    pl    din     brk   ie      NVDIZC     irq   p_out
        step(1'b1, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000100, 1'b1, 8'h24); // reset
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000100, 1'b1, 8'h24); // idle
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'b000100, 1'b1, 8'h34); // brk image
        step(1'b0, 4'b1111, 1'b1, 4'hA, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b100110, 1'b1, 8'hA6); // mask N,Z
        step(1'b0, 4'b1110, 1'b1, 4'h3, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b100111, 1'b1, 8'hA7); // SEC beats alu_c
        step(1'b0, 4'b0000, 1'b0, 4'hF, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b100111, 1'b1, 8'hA7); // mask ignored
        step(1'b0, 4'b0000, 1'b1, 4'hF, 3'd1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 6'b111111, 1'b1, 8'hEF); // PLP wins
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b101111, 1'b1, 8'hAF); // CLV
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b100111, 1'b1, 8'hA7); // CLD
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b101111, 1'b1, 8'hAF); // SED
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b101011, 1'b1, 8'hAB); // CLI, no boundary
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b101011, 1'b1, 8'hAB);
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b101011, 1'b1, 8'hAB);
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6'b101011, 1'b0, 8'hAB); // boundary
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 6'b101111, 1'b1, 8'hAF); // SEI+boundary
        step(1'b0, 4'b1011, 1'b1, 4'hF, 3'd0, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 6'b011111, 1'b1, 8'h6F); // BIT over alu
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 6'b000000, 1'b0, 8'h20); // PLP+boundary
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'hB5, 1'b0, 1'b0, 6'b100101, 1'b0, 8'hA5); // din[5:4] ignored
        step(1'b1, 4'b1111, 1'b1, 4'hF, 3'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 6'b000100, 1'b1, 8'h24); // rst beats PLP
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 6'b110011, 1'b0, 8'hE3); // first post-reset
        step(1'b0, 4'b0000, 1'b0, 4'h0, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000011, 1'b0, 8'h23); // BIT + SEC
        step(1'b0, 4'b0001, 1'b1, 4'h1, 3'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000010, 1'b0, 8'h22); // CLC beats alu_c
        step(1'b0, 4'b0001, 1'b1, 4'h1, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'b000011, 1'b0, 8'h33); // alu_c only
        step(1'b1, 4'b0000, 1'b0, 4'h0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000100, 1'b1, 8'h24); // reset again

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
